mips_muldiv: RTL
================

Name: mips_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, fed from the register file read ports alongside the ALU. Executes MULT, MULTU, DIV and DIVU over multiple cycles with a start/busy/done handshake, and single-cycle MTHI/MTLO writes. The controller stalls PC/fetch while busy=1 and reads hi/lo for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
start  input  1  command valid; sampled only when idle (busy=0)
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6-7 reserved
srca  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data)
srcb  input  WIDTH  rt operand (multiplier/divisor)
cancel  input  1  abort the in-flight mult/div (pipeline flush)
busy  output  1  operation in progress; combinational from state
done  output  1  one-cycle pulse: HI/LO updated by a mult/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- RST asserted, asynchronously: state=IDLE, hi=0, lo=0, done=0, counter=0, operand registers=0. This applies mid-operation as well. No partial result is committed.
- States are IDLE, RUN and FIN. busy = (state != IDLE).
- In IDLE with start=1 and op in 0..3, at edge E0:
  - Latch |srca| and |srcb| for signed ops, raw values for unsigned ops.
  - Latch the result-sign flags: quotient/product sign is srca[MSB]^srcb[MSB]; remainder sign is srca[MSB]. Both are used for signed ops only.
  - counter<=0, state<=RUN.
- RUN performs one iteration per edge, E1..E_WIDTH:
  - Multiply: radix-2 shift-add into a 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract giving quotient and remainder.
  - At E_WIDTH, state<=FIN.
- FIN, at edge E_WIDTH+1:
  - Apply sign correction (two's complement negate where the flag is set).
  - Write hi/lo. Multiply: hi=product[2W-1:W], lo=product[W-1:0]. Divide: lo=quotient, hi=remainder.
  - done<=1 for exactly one cycle, state<=IDLE.
- Latency: for WIDTH=32, busy is high for 33 cycles and done is high in the cycle after E33. hi/lo show the new value in that same cycle.
- Back-to-back: a new start is accepted in the first cycle busy=0, i.e. the same cycle done=1.
- start while busy: ignored, no queueing. MTHI/MTLO while busy are also ignored.
- MTHI/MTLO in IDLE: hi<=srca (MTHI) or lo<=srca (MTLO) at the next edge. busy stays 0 and done stays 0.
- Reserved op with start=1: ignored, no state change.
- cancel=1 in RUN or FIN: state<=IDLE at the next edge, hi/lo unchanged, no done pulse. cancel in IDLE has no effect. If start and cancel are both 1 in IDLE, start wins.
- Divide by zero (srcb==0), any signedness: hi=srca (original value), lo={WIDTH{1'b1}}.
- Signed overflow (DIV, srca=most-negative, srcb=-1): lo=most-negative, hi=0, i.e. wrap. No trap.
- Operands are not required to stay stable after E0; the unit uses only its latched copies.

Decomposition:
- Shared package mips_pkg:
  - muldiv_op_e enum with the op encodings above.
  - muldiv_state_e enum (IDLE/RUN/FIN).
  - MULDIV_W localparam default.
- One sub-module, muldiv_step: combinational WIDTH+1-bit add/subtract with carry-out. It is shared by the multiply add and the divide trial-subtract, and is instantiated once.

Test Plan:
1. MULTU srca=0xFFFFFFFF srcb=0xFFFFFFFF -> busy high 33 cycles, done pulse at E33+, hi=0xFFFFFFFE lo=0x00000001.
2. MULT srca=-3 (0xFFFFFFFD) srcb=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Back-to-back MULTU 6*7 issued in the done cycle -> hi=0 lo=42.
3. DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIVU 100/7 -> lo=14 hi=2. DIV 7/-2 -> lo=0xFFFFFFFD hi=1.
4. DIVU 0x12345678/0 -> hi=0x12345678 lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
5. MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A -> hi/lo updated one edge each, busy and done never asserted. Start MULT, then:
   - re-assert start with DIVU at cycle 5 -> ignored.
   - assert cancel at cycle 10 -> busy=0 next cycle, hi/lo still 0xA5A5A5A5/0x5A5A5A5A, no done.
6. Start DIVU 1000/3, assert RST at cycle 17 (asynchronously, mid-cycle) -> busy, done, hi and lo go 0 immediately. After RST release, DIVU 1000/3 completes with lo=333 hi=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation codes,
// controller states and the default datapath width.
package mips_pkg;

  localparam int MULDIV_W = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/mips_muldiv_step.sv
// WIDTH+1-bit adder/subtractor with carry-out. One instance serves both the
// shift-add of the multiplier and the trial subtract of the divider.
// With sub_i=1 the carry-out is set when a_i >= b_i (no borrow).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o,
  output logic           cout_o
);

  logic [WIDTH:0] b_eff;

  // Invert the second operand for subtraction; the +1 comes in as carry-in.
  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{(WIDTH + 1){1'b0}}, sub_i};
  end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are latched as magnitudes, WIDTH iterations of radix-2 shift-add
// or restoring shift-subtract run on a shared 2*WIDTH accumulator, and the
// sign correction is applied in the final FIN cycle when HI/LO are written.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int WIDTH = MULDIV_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Two's complement negate when en is set (WIDTH bits).
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    return en ? unsigned'(-sv) : v;
  endfunction

  // Two's complement negate when en is set (2*WIDTH bits).
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    logic signed [2*WIDTH-1:0] sv;
    sv = signed'(v);
    return en ? unsigned'(-sv) : v;
  endfunction

  // Magnitude of an operand; unsigned operations pass the raw value through.
  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v, input logic is_signed);
    return neg_w(v, is_signed & v[WIDTH-1]);
  endfunction

  muldiv_state_e      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   srca_q;     // raw dividend, returned in HI on divide by zero
  logic               is_div_q;
  logic               qsign_q;    // product/quotient negative (signed ops only)
  logic               rsign_q;    // remainder negative (signed ops only)
  logic               divzero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic               done_q;

  logic [WIDTH:0]     step_a;
  logic [WIDTH:0]     step_b;
  logic [WIDTH:0]     step_sum;
  logic               step_cout;

  muldiv_op_e         op_e;
  logic               cmd_signed;
  logic               cmd_div;

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Decode the incoming command's signedness and mul/div class.
  always_comb begin
    op_e       = muldiv_op_e'(op);
    cmd_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
    cmd_div    = (op_e == OP_DIV)  || (op_e == OP_DIVU);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .a_i    (step_a),
    .b_i    (step_b),
    .sub_i  (is_div_q),
    .sum_o  (step_sum),
    .cout_o (step_cout)
  );

  // One iteration: steer the shared adder and form the next accumulator.
  always_comb begin
    if (is_div_q) begin
      // Shift the next dividend bit into the remainder and try subtracting.
      step_a = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      step_b = {1'b0, opb_q};
      if (step_cout) begin
        acc_d = {step_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {step_a[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Add the multiplicand when the multiplier LSB is set, then shift right.
      step_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      step_b = acc_q[0] ? {1'b0, opb_q} : '0;
      acc_d  = {step_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Final HI/LO values with sign correction and the divide-by-zero rule.
  always_comb begin
    logic [2*WIDTH-1:0] prod;
    prod = neg_2w(acc_q, qsign_q);
    hi_d = prod[2*WIDTH-1:WIDTH];
    lo_d = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (divzero_q) begin
        hi_d = srca_q;
        lo_d = '1;
      end else begin
        hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH], rsign_q);
        lo_d = neg_w(acc_q[WIDTH-1:0], qsign_q);
      end
    end
  end

  // Controller and all architectural/working state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      srca_q    <= '0;
      is_div_q  <= 1'b0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op_e)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                if (cmd_div) begin
                  acc_q <= {{WIDTH{1'b0}}, mag_w(srca, cmd_signed)};
                  opb_q <= mag_w(srcb, cmd_signed);
                end else begin
                  acc_q <= {{WIDTH{1'b0}}, mag_w(srcb, cmd_signed)};
                  opb_q <= mag_w(srca, cmd_signed);
                end
                srca_q    <= srca;
                is_div_q  <= cmd_div;
                qsign_q   <= cmd_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                rsign_q   <= cmd_signed & srca[WIDTH-1];
                divzero_q <= cmd_div & (srcb == '0);
                cnt_q     <= '0;
                state_q   <= ST_RUN;
              end
              OP_MTHI: hi_q <= srca;
              OP_MTLO: lo_q <= srca;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cancel) begin
            state_q <= ST_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          if (!cancel) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
